pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush generator driving the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline regs.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/load_use_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard controller.
// Register index type, the hardwired-zero index and controller states.
package cpu_pkg;

    localparam int CPU_REG_ADDR_W = 4;

    typedef logic [CPU_REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IRQ_DRAIN = 2'd1,
        IRQ_VEC   = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// A load into r0 never creates a hazard since r0 always reads zero.
module load_use_detect
    import cpu_pkg::*;
#(
    parameter int W = CPU_REG_ADDR_W
) (
    input  logic [W-1:0] id_rs1,
    input  logic [W-1:0] id_rs2,
    input  logic         id_rs1_used,
    input  logic         id_rs2_used,
    input  logic [W-1:0] ex_reg_dst,
    input  logic         ex_mem_read,
    output logic         hazard
);

    logic dst_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    assign dst_nonzero = (ex_reg_dst != W'(REG_ZERO));
    assign rs1_hit     = id_rs1_used && (id_rs1 == ex_reg_dst);
    assign rs2_hit     = id_rs2_used && (id_rs2 == ex_reg_dst);
    assign hazard      = ex_mem_read && dst_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush generator for the IF/ID, ID/EX, EX/MEM and MEM/WB regs.
// Handles memory wait states, branch redirects, load-use bubbles and irq entry.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W       = 4,
    parameter int DATA_W           = 32,
    parameter int IRQ_DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_reg_dst,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic [DATA_W-1:0]     ex_pc_plus_4,
    input  logic                  mem_busy,
    input  logic                  irq,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  stall_mem_wb,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  pc_hold,
    output logic                  pc_sel_vector,
    output logic                  interrupt_out,
    output logic                  irq_ack,
    output logic [DATA_W-1:0]     epc
);

    localparam int CNT_W = $clog2(IRQ_DRAIN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IRQ_DRAIN_CYCLES - 1);

    hz_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic              lu_hazard;

    load_use_detect #(
        .W (REG_ADDR_W)
    ) u_lud (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_reg_dst  (ex_reg_dst),
        .ex_mem_read (ex_mem_read),
        .hazard      (lu_hazard)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        epc_d         = epc_q;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        stall_mem_wb  = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        pc_hold       = 1'b0;
        pc_sel_vector = 1'b0;
        interrupt_out = 1'b0;
        irq_ack       = 1'b0;
        // Reset holds the front end flushed so nothing issues until release.
        if (!rst_n) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_hold     = 1'b1;
        end else if (mem_busy) begin
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
            pc_hold      = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (irq) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        pc_hold     = 1'b1;
                        epc_d       = ex_pc_plus_4;
                        cnt_d       = CNT_LOAD;
                        state_d     = IRQ_DRAIN;
                    end else if (lu_hazard) begin
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        pc_hold     = 1'b1;
                    end
                end
                IRQ_DRAIN: begin
                    flush_if_id = 1'b1;
                    pc_hold     = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IRQ_VEC;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                IRQ_VEC: begin
                    pc_sel_vector = 1'b1;
                    irq_ack       = 1'b1;
                    interrupt_out = 1'b1;
                    flush_if_id   = 1'b1;
                    state_d       = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Output bundle order: stalls(4), flush_if_id, flush_id_ex, pc_hold, vec, int, ack.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [3:0]  ex_reg_dst;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic [31:0] ex_pc_plus_4;
    logic        mem_busy;
    logic        irq;
    logic        stall_if_id;
    logic        stall_id_ex;
    logic        stall_ex_mem;
    logic        stall_mem_wb;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        pc_hold;
    logic        pc_sel_vector;
    logic        interrupt_out;
    logic        irq_ack;
    logic [31:0] epc;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [9:0] O_IDLE  = 10'b0000_00_0_000;
    localparam logic [9:0] O_RST   = 10'b0000_11_1_000;
    localparam logic [9:0] O_LU    = 10'b1000_01_1_000;
    localparam logic [9:0] O_BUSY  = 10'b1111_00_1_000;
    localparam logic [9:0] O_BR    = 10'b0000_11_0_000;
    localparam logic [9:0] O_ENTRY = 10'b0000_11_1_000;
    localparam logic [9:0] O_DRAIN = 10'b0000_10_1_000;
    localparam logic [9:0] O_VEC   = 10'b0000_10_0_111;

    pipe_hazard_ctrl #(
        .REG_ADDR_W       (4),
        .DATA_W           (32),
        .IRQ_DRAIN_CYCLES (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_reg_dst      (ex_reg_dst),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_pc_plus_4    (ex_pc_plus_4),
        .mem_busy        (mem_busy),
        .irq             (irq),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .stall_ex_mem    (stall_ex_mem),
        .stall_mem_wb    (stall_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .pc_hold         (pc_hold),
        .pc_sel_vector   (pc_sel_vector),
        .interrupt_out   (interrupt_out),
        .irq_ack         (irq_ack),
        .epc             (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        #2;
        obs = {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
               flush_if_id, flush_id_ex, pc_hold,
               pc_sel_vector, interrupt_out, irq_ack};
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_epc(input string tag, input logic [31:0] exp);
        n_checks++;
        assert (epc === exp) else begin
            n_fails++;
            $error("FAIL %s: epc got %h expected %h", tag, epc, exp);
        end
    endtask

    task automatic clr_id();
        id_rs1      = '0;
        id_rs2      = '0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        ex_reg_dst  = '0;
        ex_mem_read = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        clr_id();
        ex_branch_taken = 1'b0;
        ex_pc_plus_4    = '0;
        mem_busy        = 1'b0;
        irq             = 1'b0;

        chk("reset_outputs", O_RST);
        chk_epc("reset_epc", 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("after_release", O_IDLE);
        tick();

        // load-use on rs1
        ex_mem_read = 1'b1; ex_reg_dst = 4'd5;
        id_rs1 = 4'd5; id_rs1_used = 1'b1;
        chk("lu_rs1", O_LU);
        tick();
        ex_mem_read = 1'b0;
        chk("lu_rs1_after", O_IDLE);
        tick();

        // load-use on rs2
        ex_mem_read = 1'b1; ex_reg_dst = 4'd9;
        id_rs1 = 4'd3; id_rs2 = 4'd9; id_rs2_used = 1'b1;
        chk("lu_rs2", O_LU);
        tick();
        clr_id();

        // r0 and unused source never stall
        ex_mem_read = 1'b1; ex_reg_dst = 4'd0;
        id_rs1 = 4'd0; id_rs1_used = 1'b1;
        chk("lu_r0", O_IDLE);
        tick();
        ex_reg_dst = 4'd5; id_rs1 = 4'd5; id_rs1_used = 1'b0;
        chk("lu_unused", O_IDLE);
        tick();
        ex_mem_read = 1'b0; ex_reg_dst = 4'd5;
        id_rs1_used = 1'b1;
        chk("no_load", O_IDLE);
        tick();

        // mem_busy over a load-use
        ex_mem_read = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy_%0d", i), O_BUSY);
            tick();
        end
        mem_busy = 1'b0;
        chk("busy_then_lu", O_LU);
        tick();
        clr_id();

        // branch
        ex_branch_taken = 1'b1;
        chk("branch", O_BR);
        tick();
        ex_branch_taken = 1'b0;

        // interrupt entry with a branch and mem_busy inside the drain
        irq = 1'b1; ex_pc_plus_4 = 32'h100;
        chk("irq_entry", O_ENTRY);
        tick();
        ex_pc_plus_4 = 32'h444;
        chk_epc("irq_epc", 32'h100);
        ex_branch_taken = 1'b1;
        chk("drain_1_branch", O_DRAIN);
        tick();
        ex_branch_taken = 1'b0;
        mem_busy = 1'b1;
        chk("drain_busy", O_BUSY);
        tick();
        mem_busy = 1'b0;
        chk("drain_2", O_DRAIN);
        tick();
        chk("drain_3", O_DRAIN);
        tick();
        chk("vector", O_VEC);
        tick();
        irq = 1'b0;
        chk("back_to_run", O_IDLE);
        chk_epc("epc_kept", 32'h100);
        tick();

        // branch and irq together
        irq = 1'b1; ex_branch_taken = 1'b1; ex_pc_plus_4 = 32'h200;
        chk("br_irq_same", O_BR);
        tick();
        ex_branch_taken = 1'b0; ex_pc_plus_4 = 32'h300;
        chk("irq_after_br", O_ENTRY);
        tick();
        chk_epc("epc_after_br", 32'h300);
        chk("drain_a", O_DRAIN);
        tick();

        // async reset mid-drain
        rst_n = 1'b0; irq = 1'b0;
        chk("mid_reset", O_RST);
        chk_epc("mid_reset_epc", 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_reset_%0d", i), O_IDLE);
            tick();
        end
        chk_epc("post_reset_epc", 32'h0);

        ex_mem_read = 1'b1; ex_reg_dst = 4'd7;
        id_rs2 = 4'd7; id_rs2_used = 1'b1;
        chk("resume_lu", O_LU);
        tick();
        clr_id();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
